// File: rtl/isa_pkg.sv
// Instruction-set constants, field positions and issue FSM state type shared by
// the instruction-issue front end and its FIFO.
package isa_pkg;

    localparam int INSTR_W = 16;

    localparam logic [2:0] OP_ALU = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;

    // ALU_op encodings under OP_ALU
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    // ALU_op encodings under OP_MOV
    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] MOV_IMM = 2'b10;

    localparam logic [1:0] RS_RM   = 2'b00;
    localparam logic [1:0] RS_RD   = 2'b01;
    localparam logic [1:0] RS_RN   = 2'b10;
    localparam logic [1:0] RS_NONE = 2'b11;

    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 13;
    localparam int ALU_HI   = 12;
    localparam int ALU_LO   = 11;
    localparam int RN_HI    = 10;
    localparam int RN_LO    = 8;
    localparam int RD_HI    = 7;
    localparam int RD_LO    = 5;
    localparam int SH_HI    = 4;
    localparam int SH_LO    = 3;
    localparam int RM_HI    = 2;
    localparam int RM_LO    = 0;
    localparam int IMM8_MSB = 7;
    localparam int IMM5_MSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RUN   = 2'b10
    } issue_state_t;

    function automatic logic is_legal(input logic [INSTR_W-1:0] instr);
        logic [2:0] opc;
        logic [1:0] aop;
        opc = instr[OPC_HI:OPC_LO];
        aop = instr[ALU_HI:ALU_LO];
        is_legal = (opc == OP_ALU) ||
                   ((opc == OP_MOV) && ((aop == MOV_REG) || (aop == MOV_IMM)));
    endfunction

endpackage

// File: rtl/instr_issue_fifo.sv
// Small power-of-two instruction queue; writes are dropped when full and pops
// are ignored when empty, so callers may drive push/pop unconditionally.
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_issue.sv
// Instruction front end for the datapath controller: queues words, filters
// illegal encodings, latches the IR and handshakes start/waiting.
module instr_issue
    import isa_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [INSTR_W-1:0]  in_instr,
    output logic                in_ready,
    input  logic                waiting,
    input  logic [1:0]          reg_sel,
    output logic                start,
    output logic [2:0]          opcode,
    output logic [1:0]          ALU_op,
    output logic [1:0]          shift_op,
    output logic [2:0]          r_addr,
    output logic [2:0]          w_addr,
    output logic [15:0]         sximm8,
    output logic [15:0]         sximm5,
    output logic                busy,
    output logic                illegal
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    issue_state_t       r_state;
    issue_state_t       w_state_nxt;
    logic [INSTR_W-1:0] r_ir;
    logic               r_illegal;
    logic [INSTR_W-1:0] w_head;
    logic [CNT_W-1:0]   w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_load_ir;
    logic               w_set_illegal;
    logic [2:0]         w_rn;
    logic [2:0]         w_rd;
    logic [2:0]         w_rm;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .wdata (in_instr),
        .pop   (w_pop),
        .rdata (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign in_ready = !w_full;
    assign busy     = (r_state != IDLE) || !w_empty;
    assign illegal  = r_illegal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ir      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_ir)     r_ir      <= w_head;
            if (w_set_illegal) r_illegal <= 1'b1;
        end
    end

    // Illegal heads are consumed in IDLE without ever raising start.
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_load_ir     = 1'b0;
        w_set_illegal = 1'b0;
        start         = 1'b0;
        case (r_state)
            IDLE: begin
                if ((w_count != '0) && waiting) begin
                    w_pop = 1'b1;
                    if (is_legal(w_head)) begin
                        w_load_ir   = 1'b1;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_set_illegal = 1'b1;
                    end
                end
            end
            ISSUE: begin
                start = waiting;
                if (!waiting) w_state_nxt = RUN;
            end
            RUN: begin
                if (waiting) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign opcode   = r_ir[OPC_HI:OPC_LO];
    assign ALU_op   = r_ir[ALU_HI:ALU_LO];
    assign shift_op = r_ir[SH_HI:SH_LO];
    assign w_rn     = r_ir[RN_HI:RN_LO];
    assign w_rd     = r_ir[RD_HI:RD_LO];
    assign w_rm     = r_ir[RM_HI:RM_LO];
    assign sximm8   = {{8{r_ir[IMM8_MSB]}}, r_ir[IMM8_MSB:0]};
    assign sximm5   = {{11{r_ir[IMM5_MSB]}}, r_ir[IMM5_MSB:0]};

    // Only MOV immediate writes back to Rn; everything else targets Rd.
    assign w_addr = ((opcode == OP_MOV) && (ALU_op == MOV_IMM)) ? w_rn : w_rd;

    always_comb begin
        r_addr = 3'b000;
        case (reg_sel)
            RS_RN:   r_addr = w_rn;
            RS_RD:   r_addr = w_rd;
            RS_RM:   r_addr = w_rm;
            default: r_addr = 3'b000;
        endcase
    end

endmodule
